// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: opcode values and FSM states.
package mdu_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MADD  = 3'b010;
    localparam logic [2:0] OP_MSUB  = 3'b011;
    localparam logic [2:0] OP_DIV   = 3'b100;
    localparam logic [2:0] OP_DIVU  = 3'b101;
    localparam logic [2:0] OP_MTHI  = 3'b110;
    localparam logic [2:0] OP_MTLO  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

endpackage

// File: rtl/mdu_step.sv
// One iteration of the magnitude datapath: a right-shifting shift-add multiply step
// or a left-shifting restoring-division step on the {rem, low} register pair.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] low_in,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] low_out
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             fits;

    always_comb begin
        sum     = {1'b0, rem_in} + (low_in[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        shifted = {rem_in, low_in[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, operand};
        fits    = ~diff[WIDTH+1];
        if (is_div) begin
            // Remainder stays below the divisor, so it always fits in WIDTH bits.
            rem_out = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
            low_out = {low_in[WIDTH-2:0], fits};
        end else begin
            rem_out = sum[WIDTH:1];
            low_out = {sum[0], low_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning HI/LO; magnitudes are iterated and the
// sign correction plus accumulate/subtract happen in a single FIX cycle.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t           state;
    logic [CW-1:0]    count;
    logic [2:0]       op_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] operand_reg;
    logic [WIDTH-1:0] upper_reg;
    logic [WIDTH-1:0] low_reg;
    logic             neg_res;
    logic             neg_rem;
    logic             div_zero;

    logic             is_signed;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    always_comb begin
        is_signed = (Op == OP_MULT) || (Op == OP_MADD) || (Op == OP_MSUB) || (Op == OP_DIV);
        a_mag     = (is_signed && A[WIDTH-1]) ? (WIDTH'(0) - A) : A;
        b_mag     = (is_signed && B[WIDTH-1]) ? (WIDTH'(0) - B) : B;
    end

    logic [WIDTH-1:0] rem_chain [0:BITS_PER_CYCLE];
    logic [WIDTH-1:0] low_chain [0:BITS_PER_CYCLE];

    assign rem_chain[0] = upper_reg;
    assign low_chain[0] = low_reg;

    generate
        for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
            mdu_step #(.WIDTH(WIDTH)) u_step (
                .is_div  (state == ST_DIV),
                .rem_in  (rem_chain[gi]),
                .low_in  (low_chain[gi]),
                .operand (operand_reg),
                .rem_out (rem_chain[gi+1]),
                .low_out (low_chain[gi+1])
            );
        end
    endgenerate

    logic [2*WIDTH-1:0] product_mag;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [2*WIDTH-1:0] fix_result;

    always_comb begin
        product_mag = {upper_reg, low_reg};
        product     = neg_res ? ((2*WIDTH)'(0) - product_mag) : product_mag;
        quot        = neg_res ? (WIDTH'(0) - low_reg) : low_reg;
        rem         = neg_rem ? (WIDTH'(0) - upper_reg) : upper_reg;
        case (op_reg)
            OP_MULT, OP_MULTU: fix_result = product;
            OP_MADD:           fix_result = {HI, LO} + product;
            OP_MSUB:           fix_result = {HI, LO} - product;
            OP_DIV, OP_DIVU:   fix_result = div_zero ? {a_reg, {WIDTH{1'b1}}} : {rem, quot};
            default:           fix_result = {HI, LO};
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= ST_IDLE;
            count       <= '0;
            op_reg      <= '0;
            a_reg       <= '0;
            operand_reg <= '0;
            upper_reg   <= '0;
            low_reg     <= '0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            div_zero    <= 1'b0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            DivByZero   <= 1'b0;
            HI          <= '0;
            LO          <= '0;
        end else begin
            Done      <= 1'b0;
            DivByZero <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        case (Op)
                            OP_MTHI: begin
                                HI   <= A;
                                Done <= 1'b1;
                            end
                            OP_MTLO: begin
                                LO   <= A;
                                Done <= 1'b1;
                            end
                            default: begin
                                op_reg      <= Op;
                                a_reg       <= A;
                                operand_reg <= b_mag;
                                upper_reg   <= '0;
                                low_reg     <= a_mag;
                                neg_res     <= is_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
                                neg_rem     <= is_signed && A[WIDTH-1];
                                div_zero    <= Op[2] && (B == '0);
                                count       <= '0;
                                Busy        <= 1'b1;
                                state       <= Op[2] ? ST_DIV : ST_MUL;
                            end
                        endcase
                    end
                end
                ST_MUL, ST_DIV: begin
                    upper_reg <= rem_chain[BITS_PER_CYCLE];
                    low_reg   <= low_chain[BITS_PER_CYCLE];
                    count     <= count + 1'b1;
                    if (count == LAST) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    {HI, LO}  <= fix_result;
                    Busy      <= 1'b0;
                    Done      <= 1'b1;
                    DivByZero <= div_zero;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: a 1-bit/cycle and a 4-bit/cycle instance,
// expected HI/LO/DivByZero pushed to a scoreboard queue at issue and popped on Done.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start1, start2;
    logic [2:0]  op_s;
    logic [31:0] a_s, b_s;
    logic        busy1, done1, dbz1;
    logic        busy2, done2, dbz2;
    logic [31:0] hi1, lo1, hi2, lo2;

    int compared   = 0;
    int mismatched = 0;
    int cyc;
    int ndone;

    logic [64:0] sb_q [$];

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut1 (
        .Clk(clk), .Rst_n(rst_n), .Start(start1), .Op(op_s), .A(a_s), .B(b_s),
        .Busy(busy1), .Done(done1), .DivByZero(dbz1), .HI(hi1), .LO(lo1)
    );

    mul_div_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut2 (
        .Clk(clk), .Rst_n(rst_n), .Start(start2), .Op(op_s), .A(a_s), .B(b_s),
        .Busy(busy2), .Done(done2), .DivByZero(dbz2), .HI(hi2), .LO(lo2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one operation, wait (bounded) for Done, then compare against the popped expectation.
    task automatic run_op(input int sel, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic exp_dbz,
                          input int lat, input string tag);
        int          cycles;
        int          busy_cnt;
        logic [64:0] exp;
        cycles   = 0;
        busy_cnt = 0;
        @(negedge clk);
        op_s = op;
        a_s  = a;
        b_s  = b;
        if (sel == 0) start1 = 1'b1; else start2 = 1'b1;
        sb_q.push_back({exp_hi, exp_lo, exp_dbz});
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start2 = 1'b0;
        a_s  = $urandom;
        b_s  = $urandom;
        op_s = 3'($urandom);
        while (!((sel == 0) ? done1 : done2) && cycles < 100) begin
            if ((sel == 0) ? busy1 : busy2) busy_cnt++;
            @(posedge clk);
            #1;
            cycles++;
        end
        exp = sb_q.pop_front();
        check({tag, "_latency"}, 64'(cycles), 64'(lat));
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(lat));
        check({tag, "_hi"}, 64'((sel == 0) ? hi1 : hi2), 64'(exp[64:33]));
        check({tag, "_lo"}, 64'((sel == 0) ? lo1 : lo2), 64'(exp[32:1]));
        check({tag, "_dbz"}, 64'((sel == 0) ? dbz1 : dbz2), 64'(exp[0]));
        $display("txn %s: dut%0d hi=%h lo=%h dbz=%0b after %0d cycles", tag, sel + 1,
                 (sel == 0) ? hi1 : hi2, (sel == 0) ? lo1 : lo2,
                 (sel == 0) ? dbz1 : dbz2, cycles);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 64'((sel == 0) ? done1 : done2), 64'(0));
    endtask

    initial begin
        rst_n  = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        op_s   = 3'b000;
        a_s    = '0;
        b_s    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy1), 64'(0));
        check("reset_done", 64'(done1), 64'(0));
        check("reset_dbz",  64'(dbz1),  64'(0));
        check("reset_hilo", {hi1, lo1}, 64'(0));
        check("reset_hilo_b4", {hi2, lo2}, 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_op(0, 3'b000, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33, "mult_neg");
        run_op(0, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33, "multu_max");
        run_op(0, 3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33, "mult_minmin");
        run_op(0, 3'b110, 32'd5, 32'd0, 32'd5, 32'h00000000, 1'b0, 0, "mthi");
        run_op(0, 3'b111, 32'd10, 32'd0, 32'd5, 32'd10, 1'b0, 0, "mtlo");
        run_op(0, 3'b010, 32'd2, 32'd3, 32'd5, 32'd16, 1'b0, 33, "madd");
        run_op(0, 3'b011, 32'hFFFFFFFF, 32'd20, 32'd5, 32'd36, 1'b0, 33, "msub");
        run_op(0, 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, "div_neg");
        run_op(0, 3'b101, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, 33, "divu");
        run_op(0, 3'b101, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF, 1'b0, 33, "divu_big");
        run_op(0, 3'b100, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF, 1'b1, 33, "div_zero");
        run_op(0, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 33, "div_ovf");

        // A second Start while busy must be dropped; the first result stands.
        @(negedge clk);
        op_s = 3'b000; a_s = 32'd3; b_s = 32'd4; start1 = 1'b1;
        sb_q.push_back({32'd0, 32'd12, 1'b0});
        @(posedge clk);
        #1;
        start1 = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        op_s = 3'b000; a_s = 32'd100; b_s = 32'd100; start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        cyc = 6;
        while (!done1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        begin
            logic [64:0] exp;
            exp = sb_q.pop_front();
            check("busy_ignore_latency", 64'(cyc), 64'(33));
            check("busy_ignore_hilo", {hi1, lo1}, exp[64:1]);
        end
        $display("txn busy_ignore: dut1 hi=%h lo=%h after %0d cycles", hi1, lo1, cyc);
        ndone = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done1) ndone++;
        end
        check("busy_ignore_no_second_done", 64'(ndone), 64'(0));

        // Reset in the middle of an iteration aborts immediately.
        @(negedge clk);
        op_s = 3'b001; a_s = 32'd1234; b_s = 32'd5678; start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_busy", 64'(busy1), 64'(0));
        check("midreset_hilo", {hi1, lo1}, 64'(0));
        $display("txn midreset: dut1 busy=%0b hi=%h lo=%h", busy1, hi1, lo1);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done1) ndone++;
        end
        check("midreset_no_done", 64'(ndone), 64'(0));
        check("midreset_hilo_after", {hi1, lo1}, 64'(0));

        run_op(1, 3'b000, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 9, "b4_mult");
        run_op(1, 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 9, "b4_div");
        run_op(1, 3'b100, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF, 1'b1, 9, "b4_div_zero");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle integer multiply/divide unit owning the architectural HI/LO register pair.
- Replaces single-cycle HI/LO arithmetic with an iterative, parametrised datapath.
- Adds DIV/DIVU and a Start/Busy/Done handshake.
- Sits beside the ALU in EX. The pipeline stalls on Busy and reads HI/LO directly for MFHI/MFLO.

Parameters:
- WIDTH, 32: operand and HI/LO width.
- BITS_PER_CYCLE, 1: bits retired per iteration. Must divide WIDTH. N = WIDTH/BITS_PER_CYCLE iterations.

Ports:
- Clk  in  1  rising-edge clock
- Rst_n  in  1  asynchronous, active-low reset
- Start  in  1  request; sampled only when Busy=0
- Op  in  3  000 MULT, 001 MULTU, 010 MADD, 011 MSUB, 100 DIV, 101 DIVU, 110 MTHI, 111 MTLO
- A  in  WIDTH  rs operand
- B  in  WIDTH  rt operand
- Busy  out  1  iterative operation in flight
- Done  out  1  one-cycle pulse; HI/LO hold the new result
- DivByZero  out  1  pulses with Done when a DIV/DIVU had B=0
- HI  out  WIDTH  architectural HI
- LO  out  WIDTH  architectural LO

Behaviour:
- Reset (async, Rst_n=0): state=IDLE; Busy=Done=DivByZero=0; HI=LO=0. Reset mid-operation aborts it with no HI/LO update.
- States: IDLE, MUL, DIV, FIX.
  - IDLE & Start & Op∈{MULT,MULTU,MADD,MSUB} -> MUL
  - IDLE & Start & Op∈{DIV,DIVU} -> DIV
  - MUL/DIV after N iterations -> FIX
  - FIX -> IDLE
- Operand latching: A, B and Op are latched at the Start edge. Inputs are don't-care afterwards.
- Signed ops: operands are converted to magnitudes at latch; sign correction is applied in FIX.
- Latency: Start accepted at edge k. Iterations run at edges k+1..k+N. FIX at edge k+N+1 writes HI/LO, deasserts Busy, and sets Done=1 for exactly one cycle. Busy=1 from edge k through edge k+N+1.
- Multiply:
  - Shift-add, 2*WIDTH-bit product.
  - MULT is signed, MULTU unsigned.
  - MADD: {HI,LO} = {HI,LO} + signed product. MSUB: {HI,LO} = {HI,LO} - signed product. Both use the HI/LO value present at FIX, wrap modulo 2^(2*WIDTH).
- Divide:
  - Restoring division. LO = quotient, HI = remainder.
  - Signed quotient truncates toward zero; remainder takes the sign of the dividend.
  - -2^(WIDTH-1) / -1 gives LO = -2^(WIDTH-1), HI = 0 (wrap, no flag).
  - B=0: full latency still runs; LO = all ones, HI = A; DivByZero=1 alongside Done.
- MTHI/MTLO: Start in IDLE writes HI (or LO) = A at that edge. Busy stays 0. Done pulses the next cycle.
- Start while Busy=1 is ignored (no queueing). Start in the cycle Done=1 is accepted normally; Busy re-asserts the following cycle.
- Zero operands take the full latency (no early termination), so latency is deterministic.

Decomposition:
- Package mdu_pkg:
  - Op encodings as localparams (OP_MULT..OP_MTLO).
  - State encoding (ST_IDLE, ST_MUL, ST_DIV, ST_FIX).
- Sub-module mdu_step: combinational single-bit shift-add / restore step for one iteration. Instantiated BITS_PER_CYCLE times in a chain by a generate loop.
- Top level holds the FSM, iteration counter ($clog2(N+1) bits), operand/accumulator registers and sign-fix logic.

Test Plan:
1. MULT A=0xFFFFFFFD (-3), B=7 -> Done exactly 33 edges after Start; HI=0xFFFFFFFF, LO=0xFFFFFFEB; Busy high for 33 cycles.
2. MULTU A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
3. MTHI 5, MTLO 10, then MADD A=2, B=3 -> HI=5, LO=16. Then MSUB A=0xFFFFFFFF (-1), B=20 -> HI=5, LO=36.
4. DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2 -> LO=3, HI=1.
5. DIV A=9, B=0 -> DivByZero=1 with Done; LO=0xFFFFFFFF, HI=9. DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0, DivByZero=0.
6. Busy and reset handling:
   - Start a MULT while Busy -> the new request is ignored and the original result stands.
   - Drive Rst_n=0 at iteration 10 -> Busy=0, HI=LO=0 immediately.
   - With BITS_PER_CYCLE=4, rerun scenario 1 -> Done 9 edges after Start with the same result.
